// File: rtl/key_repeat_ctrl_pkg.sv
// Shared types and default timing for the key repeat controller.
//   rpt_state_t     : per-channel repeat FSM state
//   *_CYCLES_DEF    : default DAS / ARR / soft-drop periods at 100 MHz
//   max2            : helper used to size down-counters
package key_repeat_ctrl_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int DAS_CYCLES_DEF  = 16_700_000;  // 167 ms
    localparam int ARR_CYCLES_DEF  = 3_300_000;   // 33 ms
    localparam int SOFT_CYCLES_DEF = 5_000_000;   // 50 ms

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            max2 = a;
        end else begin
            max2 = b;
        end
    endfunction

endpackage

// File: rtl/key_repeat_channel.sv
// One auto-repeat channel: strobe on start, optional initial delay, then a
// fixed repeat period while the key stays held.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force IDLE with counter cleared (disable or lost arbitration)
//   start    : begin a press sequence; only honoured in IDLE
//   held     : key level; low returns the channel to IDLE
//   strobe   : registered one-cycle pulse
module key_repeat_channel
    import key_repeat_ctrl_pkg::*;
#(
    parameter int FIRST_CYCLES = DAS_CYCLES_DEF,
    parameter int RPT_CYCLES   = ARR_CYCLES_DEF,
    parameter bit USE_DELAY    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic start,
    input  logic held,
    output logic strobe
);

    localparam int CNT_W = $clog2(max2(FIRST_CYCLES, RPT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LOAD   = CNT_W'(RPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    rpt_state_t       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             strobe_r, strobe_next_s;

    assign strobe = strobe_r;

    // State, counter and strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RPT_IDLE;
            cnt_r    <= CNT_ZERO;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            strobe_r <= strobe_next_s;
        end
    end

    // Next-state, counter and strobe decision
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        strobe_next_s = 1'b0;
        if (clear || !held) begin
            state_next_s = RPT_IDLE;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                RPT_IDLE: begin
                    if (start) begin
                        strobe_next_s = 1'b1;
                        if (USE_DELAY) begin
                            state_next_s = RPT_DELAY;
                            cnt_next_s   = FIRST_LOAD;
                        end else begin
                            state_next_s = RPT_REPEAT;
                            cnt_next_s   = RPT_LOAD;
                        end
                    end else begin
                        state_next_s = RPT_IDLE;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    // Reload happens only at zero, so the counter never wraps.
                    if (cnt_r == CNT_ZERO) begin
                        strobe_next_s = 1'b1;
                        state_next_s  = RPT_REPEAT;
                        cnt_next_s    = RPT_LOAD;
                    end else begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = RPT_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_repeat_ctrl.sv
// Turns held-key levels into the single-cycle key strobes for game_control.
// Left/right get DAS + ARR repeat with last-pressed-wins arbitration, down
// gets a fixed soft-drop repeat, rotate/drop/hold pulse once per press.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : 0 suppresses every strobe and key_drop_held
//   held_*          : synchronised key levels
//   key_*           : registered one-cycle strobes
//   key_drop_held   : registered held_drop & enable
module key_repeat_ctrl
    import key_repeat_ctrl_pkg::*;
#(
    parameter int DAS_CYCLES  = DAS_CYCLES_DEF,
    parameter int ARR_CYCLES  = ARR_CYCLES_DEF,
    parameter int SOFT_CYCLES = SOFT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic held_left,
    input  logic held_right,
    input  logic held_down,
    input  logic held_rot_cw,
    input  logic held_rot_ccw,
    input  logic held_drop,
    input  logic held_hold,
    output logic key_left,
    output logic key_right,
    output logic key_down,
    output logic key_rotate_cw,
    output logic key_rotate_ccw,
    output logic key_drop,
    output logic key_hold,
    output logic key_drop_held
);

    logic [6:0] held_s, held_q_r, rise_s;
    logic       valid_r;
    logic       fall_left_s, fall_right_s;
    logic       clr_left_s, clr_right_s, clr_down_s;
    logic       start_left_s, start_right_s;

    assign held_s = {held_left, held_right, held_down, held_rot_cw,
                     held_rot_ccw, held_drop, held_hold};

    // held_q is zero straight out of reset, which would look like a press for
    // any key already down; valid_r masks edges for that first cycle so a key
    // held through reset needs a fresh press.
    assign rise_s       = held_s & ~held_q_r & {7{valid_r}};
    assign fall_left_s  = ~held_left  & held_q_r[6] & valid_r;
    assign fall_right_s = ~held_right & held_q_r[5] & valid_r;

    // Right wins a same-cycle tie. A winner's release restarts a still-held
    // loser; start is ignored by a channel that is already running.
    assign clr_left_s    = ~enable | rise_s[5];
    assign clr_right_s   = ~enable | (rise_s[6] & ~rise_s[5]);
    assign clr_down_s    = ~enable;
    assign start_left_s  = rise_s[6] | (fall_right_s & held_left);
    assign start_right_s = rise_s[5] | (fall_left_s & held_right);

    // Previous key levels, tracked even while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q_r <= 7'd0;
            valid_r  <= 1'b0;
        end else begin
            held_q_r <= held_s;
            valid_r  <= 1'b1;
        end
    end

    // One-shot strobes and the drop-held level
    always_ff @(posedge clk) begin
        if (rst) begin
            key_rotate_cw  <= 1'b0;
            key_rotate_ccw <= 1'b0;
            key_drop       <= 1'b0;
            key_hold       <= 1'b0;
            key_drop_held  <= 1'b0;
        end else begin
            key_rotate_cw  <= enable & rise_s[3];
            key_rotate_ccw <= enable & rise_s[2];
            key_drop       <= enable & rise_s[1];
            key_hold       <= enable & rise_s[0];
            key_drop_held  <= enable & held_drop;
        end
    end

    key_repeat_channel #(
        .FIRST_CYCLES(DAS_CYCLES),
        .RPT_CYCLES  (ARR_CYCLES),
        .USE_DELAY   (1'b1)
    ) u_left (
        .clk   (clk),
        .rst   (rst),
        .clear (clr_left_s),
        .start (start_left_s),
        .held  (held_left),
        .strobe(key_left)
    );

    key_repeat_channel #(
        .FIRST_CYCLES(DAS_CYCLES),
        .RPT_CYCLES  (ARR_CYCLES),
        .USE_DELAY   (1'b1)
    ) u_right (
        .clk   (clk),
        .rst   (rst),
        .clear (clr_right_s),
        .start (start_right_s),
        .held  (held_right),
        .strobe(key_right)
    );

    key_repeat_channel #(
        .FIRST_CYCLES(SOFT_CYCLES),
        .RPT_CYCLES  (SOFT_CYCLES),
        .USE_DELAY   (1'b0)
    ) u_down (
        .clk   (clk),
        .rst   (rst),
        .clear (clr_down_s),
        .start (rise_s[4]),
        .held  (held_down),
        .strobe(key_down)
    );

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with DAS=8, ARR=3, SOFT=2.
// Inputs for step i are applied before clock edge i; outputs are sampled 1
// time unit after that edge. Output vector bit order:
//   {left, right, down, rot_cw, rot_ccw, drop, hold, drop_held}
module tb_key_repeat_ctrl;

    logic clk = 1'b0;
    logic rst, enable;
    logic held_left, held_right, held_down, held_rot_cw, held_rot_ccw;
    logic held_drop, held_hold;
    logic key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw;
    logic key_drop, key_hold, key_drop_held;
    logic [7:0] outs_s;
    logic [7:0] e;
    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    key_repeat_ctrl #(
        .DAS_CYCLES (8),
        .ARR_CYCLES (3),
        .SOFT_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .held_left     (held_left),
        .held_right    (held_right),
        .held_down     (held_down),
        .held_rot_cw   (held_rot_cw),
        .held_rot_ccw  (held_rot_ccw),
        .held_drop     (held_drop),
        .held_hold     (held_hold),
        .key_left      (key_left),
        .key_right     (key_right),
        .key_down      (key_down),
        .key_rotate_cw (key_rotate_cw),
        .key_rotate_ccw(key_rotate_ccw),
        .key_drop      (key_drop),
        .key_hold      (key_hold),
        .key_drop_held (key_drop_held)
    );

    assign outs_s = {key_left, key_right, key_down, key_rotate_cw,
                     key_rotate_ccw, key_drop, key_hold, key_drop_held};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, outs_s, exp);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        held_left = 1'b0; held_right = 1'b0; held_down = 1'b0;
        held_rot_cw = 1'b0; held_rot_ccw = 1'b0; held_drop = 1'b0; held_hold = 1'b0;
        step("reset_a", 8'b0);
        step("reset_b", 8'b0);
        rst = 1'b0; enable = 1'b1;
        step("idle_a", 8'b0);
        step("idle_b", 8'b0);

        // 1: DAS then ARR on left
        for (int i = 0; i < 34; i++) begin
            held_left = (i >= 10 && i < 30);
            e = 8'b0;
            e[7] = (i == 10 || i == 18 || i == 21 || i == 24 || i == 27);
            step($sformatf("t1_c%0d", i), e);
        end

        // 2: one-shot keys, simultaneous rotate rises, drop_held level
        for (int i = 0; i < 13; i++) begin
            held_rot_cw  = (i == 1);
            held_rot_ccw = (i == 1);
            held_drop    = (i >= 3 && i < 8);
            held_hold    = (i == 9);
            e = 8'b0;
            e[4] = (i == 1);
            e[3] = (i == 1);
            e[2] = (i == 3);
            e[0] = (i >= 3 && i < 8);
            e[1] = (i == 9);
            step($sformatf("t2_c%0d", i), e);
        end

        // 3: right overrides left, release of right restarts left
        for (int i = 0; i < 33; i++) begin
            held_left  = (i < 30);
            held_right = (i >= 4 && i < 15);
            e = 8'b0;
            e[7] = (i == 0 || i == 15 || i == 23 || i == 26 || i == 29);
            e[6] = (i == 4 || i == 12);
            step($sformatf("t3_c%0d", i), e);
        end

        // 4: soft drop repeat
        for (int i = 0; i < 10; i++) begin
            held_down = (i < 7);
            e = 8'b0;
            e[5] = (i == 0 || i == 2 || i == 4 || i == 6);
            step($sformatf("t4_c%0d", i), e);
        end

        // 5: key held across enable rise needs a re-press
        for (int i = 0; i < 12; i++) begin
            enable    = (i >= 3);
            held_left = (i < 6) || (i >= 8 && i < 10);
            held_drop = (i < 2);
            e = 8'b0;
            e[7] = (i == 8);
            step($sformatf("t5_c%0d", i), e);
        end
        enable = 1'b1;

        // 6: reset during repeat, key held through reset
        for (int i = 0; i < 24; i++) begin
            held_left = (i < 17) || (i >= 19 && i < 21);
            rst       = (i == 12 || i == 13);
            e = 8'b0;
            e[7] = (i == 0 || i == 8 || i == 11 || i == 19);
            step($sformatf("t6_c%0d", i), e);
        end
        rst = 1'b0;

        // 7: same-cycle left/right rise, right wins
        for (int i = 0; i < 6; i++) begin
            held_left  = (i < 3);
            held_right = (i < 3);
            e = 8'b0;
            e[6] = (i == 0);
            step($sformatf("t7_c%0d", i), e);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
